// File: rtl/tx_pause_sched_if.sv
// AXI4-Stream bundle used for both the user TX input and the MAC TX output.
// master drives payload/valid, slave drives ready.
interface tx_pause_sched_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/tx_pause_sched.sv
// TX flow-control scheduler: gates user frames at frame boundaries while the partner
// has paused us and inserts locally generated 802.3x PAUSE (XOFF/XON) frames.
module tx_pause_sched #(
  parameter int unsigned REFRESH_W = 16
) (
  input  logic                 clk,
  input  logic                 aresetn,
  tx_pause_sched_if.slave      s_axis,
  tx_pause_sched_if.master     m_axis,
  input  logic                 rx_pause_active,
  input  logic                 xoff_req,
  input  logic                 cfg_tx_pause_enable,
  input  logic                 cfg_xon_enable,
  input  logic [47:0]          cfg_mac_sa,
  input  logic [15:0]          cfg_pause_quanta,
  input  logic [REFRESH_W-1:0] cfg_refresh_interval,
  output logic                 stat_pause_tx,
  output logic                 tx_held
);

  typedef enum logic [1:0] {StIdle, StUser, StPauseTx} state_e;

  localparam logic [2:0] LastBeat = 3'd7;

  state_e               state_q, state_d;
  logic [2:0]           beat_q, beat_d;
  logic [15:0]          tx_quanta_q, tx_quanta_d;
  logic [47:0]          tx_sa_q, tx_sa_d;
  logic                 pending_q, pending_d;
  logic [15:0]          req_quanta_q, req_quanta_d;
  logic [REFRESH_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic                 xoff_q;
  logic                 stat_q, stat_d;

  logic                 xoff_rise, xoff_fall;
  logic                 req;
  logic [15:0]          req_val;
  logic                 pause_done;
  logic [63:0]          pause_word;

  assign xoff_rise = xoff_req & ~xoff_q;
  assign xoff_fall = ~xoff_req & xoff_q;

  // Request generation: rise, periodic refresh while held, optional XON on fall.
  always_comb begin
    req           = 1'b0;
    req_val       = cfg_pause_quanta;
    refresh_cnt_d = refresh_cnt_q;
    if (!cfg_tx_pause_enable) begin
      refresh_cnt_d = '0;
    end else if (xoff_rise) begin
      req           = 1'b1;
      refresh_cnt_d = '0;
    end else if (xoff_req) begin
      if (cfg_refresh_interval == '0) begin
        refresh_cnt_d = '0;
      end else if (refresh_cnt_q == cfg_refresh_interval - REFRESH_W'(1)) begin
        req           = 1'b1;
        refresh_cnt_d = '0;
      end else begin
        refresh_cnt_d = refresh_cnt_q + REFRESH_W'(1);
      end
    end else begin
      refresh_cnt_d = '0;
      if (xoff_fall && cfg_xon_enable) begin
        req     = 1'b1;
        req_val = 16'h0000;
      end
    end
  end

  // Latest request wins; a request coinciding with frame completion stays pending.
  always_comb begin
    pending_d    = pending_q;
    req_quanta_d = req_quanta_q;
    if (pause_done) begin
      pending_d = 1'b0;
    end
    if (req) begin
      pending_d    = 1'b1;
      req_quanta_d = req_val;
    end
    if (!cfg_tx_pause_enable) begin
      pending_d = 1'b0;
    end
  end

  assign pause_done = (state_q == StPauseTx) && m_axis.tready && (beat_q == LastBeat);

  // PAUSE frame payload, byte n of the frame at tdata[8n+7:8n] of its beat.
  always_comb begin
    pause_word = 64'h0;
    case (beat_q)
      3'd0: pause_word = {tx_sa_q[39:32], tx_sa_q[47:40], 8'h01, 8'h00,
                          8'h00, 8'hC2, 8'h80, 8'h01};
      3'd1: pause_word = {8'h01, 8'h00, 8'h08, 8'h88,
                          tx_sa_q[7:0], tx_sa_q[15:8], tx_sa_q[23:16], tx_sa_q[31:24]};
      3'd2: pause_word = {48'h0, tx_quanta_q[7:0], tx_quanta_q[15:8]};
      default: pause_word = 64'h0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tx_quanta_d   = tx_quanta_q;
    tx_sa_d       = tx_sa_q;
    stat_d        = 1'b0;
    m_axis.tdata  = 64'h0;
    m_axis.tkeep  = 8'h00;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    s_axis.tready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d     = StPauseTx;
          beat_d      = 3'd0;
          tx_quanta_d = req_quanta_q;
          tx_sa_d     = cfg_mac_sa;
        end else if (s_axis.tvalid && !rx_pause_active) begin
          state_d = StUser;
        end
      end
      StUser: begin
        m_axis.tdata  = s_axis.tdata;
        m_axis.tkeep  = s_axis.tkeep;
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tlast  = s_axis.tlast;
        s_axis.tready = m_axis.tready;
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
          state_d = StIdle;
        end
      end
      StPauseTx: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = pause_word;
        m_axis.tkeep  = (beat_q == LastBeat) ? 8'h0F : 8'hFF;
        m_axis.tlast  = (beat_q == LastBeat);
        if (m_axis.tready) begin
          if (beat_q == LastBeat) begin
            state_d = StIdle;
            stat_d  = 1'b1;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      beat_q        <= 3'd0;
      tx_quanta_q   <= 16'h0;
      tx_sa_q       <= 48'h0;
      pending_q     <= 1'b0;
      req_quanta_q  <= 16'h0;
      refresh_cnt_q <= '0;
      xoff_q        <= 1'b0;
      stat_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      tx_quanta_q   <= tx_quanta_d;
      tx_sa_q       <= tx_sa_d;
      pending_q     <= pending_d;
      req_quanta_q  <= req_quanta_d;
      refresh_cnt_q <= refresh_cnt_d;
      xoff_q        <= xoff_req;
      stat_q        <= stat_d;
    end
  end

  assign stat_pause_tx = stat_q;
  assign tx_held       = (state_q == StIdle) && s_axis.tvalid && rx_pause_active;

endmodule

// File: tb/tb_tx_pause_sched.sv
// Directed/randomized bench for tx_pause_sched: expected output beats are built from
// frame-format rules and request timing, then compared with beats captured on m_axis.
module tb_tx_pause_sched;

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        rx_pause_active;
  logic        xoff_req;
  logic        cfg_tx_pause_enable;
  logic        cfg_xon_enable;
  logic [47:0] cfg_mac_sa;
  logic [15:0] cfg_pause_quanta;
  logic [15:0] cfg_refresh_interval;
  logic        stat_pause_tx;
  logic        tx_held;

  tx_pause_sched_if s_axis ();
  tx_pause_sched_if m_axis ();

  tx_pause_sched #(.REFRESH_W(16)) dut (
    .clk                  (clk),
    .aresetn              (aresetn),
    .s_axis               (s_axis),
    .m_axis               (m_axis),
    .rx_pause_active      (rx_pause_active),
    .xoff_req             (xoff_req),
    .cfg_tx_pause_enable  (cfg_tx_pause_enable),
    .cfg_xon_enable       (cfg_xon_enable),
    .cfg_mac_sa           (cfg_mac_sa),
    .cfg_pause_quanta     (cfg_pause_quanta),
    .cfg_refresh_interval (cfg_refresh_interval),
    .stat_pause_tx        (stat_pause_tx),
    .tx_held              (tx_held)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t cap_q[$];
  beat_t exp_q[$];
  int    start_q[$];
  int    cyc = 0;
  int    stat_cnt = 0;
  logic  tv_prev = 1'b0;
  bit    rand_rdy = 1'b0;
  bit    rdy_fixed = 1'b1;

  // Monitor: captured handshakes, frame start cycles, stat pulses.
  always @(posedge clk) begin
    if (aresetn && m_axis.tvalid && m_axis.tready)
      cap_q.push_back('{last: m_axis.tlast, keep: m_axis.tkeep, data: m_axis.tdata});
    if (aresetn && m_axis.tvalid && !tv_prev) start_q.push_back(cyc);
    tv_prev <= m_axis.tvalid;
    cyc     <= cyc + 1;
    if (stat_pause_tx) stat_cnt <= stat_cnt + 1;
  end

  // Downstream ready: fixed, or random with at most two consecutive stall cycles.
  initial begin
    int low_run = 0;
    m_axis.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        if (low_run >= 2 || $urandom_range(0, 3) != 0) begin
          m_axis.tready = 1'b1;
          low_run = 0;
        end else begin
          m_axis.tready = 1'b0;
          low_run++;
        end
      end else begin
        m_axis.tready = rdy_fixed;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference PAUSE frame built from its byte layout (60 bytes, lanes little-endian).
  function automatic void push_pause(logic [47:0] sa, logic [15:0] q);
    logic [7:0] fb [64];
    beat_t      b;
    foreach (fb[i]) fb[i] = 8'h00;
    fb[0] = 8'h01; fb[1] = 8'h80; fb[2] = 8'hC2; fb[5] = 8'h01;
    for (int i = 0; i < 6; i++) fb[6 + i] = sa[47 - 8 * i -: 8];
    fb[12] = 8'h88; fb[13] = 8'h08; fb[15] = 8'h01;
    fb[16] = q[15:8]; fb[17] = q[7:0];
    for (int bi = 0; bi < 8; bi++) begin
      b.data = 64'h0;
      for (int l = 0; l < 8; l++) b.data[8 * l +: 8] = fb[8 * bi + l];
      b.keep = (bi == 7) ? 8'h0F : 8'hFF;
      b.last = (bi == 7);
      exp_q.push_back(b);
    end
  endfunction

  task automatic drive_beat(logic [63:0] d, logic [7:0] k, logic l);
    s_axis.tdata  = d;
    s_axis.tkeep  = k;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    exp_q.push_back('{last: l, keep: k, data: d});
  endtask

  task automatic wait_hs(string tag);
    int n  = 0;
    bit hs = 1'b0;
    while (!hs && n < 300) begin
      @(posedge clk);
      hs = s_axis.tvalid && s_axis.tready;
      n++;
    end
    #1;
    s_axis.tvalid = 1'b0;
    chk({tag, " handshake"}, 64'(hs), 64'd1);
  endtask

  task automatic compare_all(string tag);
    int    n = 0;
    int    idx = 0;
    beat_t g, e;
    while (cap_q.size() < exp_q.size() && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " beat count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      g = cap_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s beat%0d data", tag, idx), g.data, e.data);
      chk($sformatf("%s beat%0d keep/last", tag, idx), 64'({g.last, g.keep}),
          64'({e.last, e.keep}));
      idx++;
    end
    exp_q.delete();
    cap_q.delete();
  endtask

  initial begin
    int          stat_base;
    int          exp_gap [4] = '{100, 100, 100, 50};
    logic [15:0] q;

    s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    rx_pause_active = 1'b0; xoff_req = 1'b0;
    cfg_tx_pause_enable = 1'b0; cfg_xon_enable = 1'b0;
    cfg_mac_sa = 48'h001122334455; cfg_pause_quanta = 16'hFFFF; cfg_refresh_interval = '0;
    aresetn = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst tlast", 64'(m_axis.tlast), 64'd0);
    chk("rst tkeep", 64'(m_axis.tkeep), 64'd0);
    chk("rst tdata", m_axis.tdata, 64'd0);
    chk("rst s_tready", 64'(s_axis.tready), 64'd0);
    chk("rst stat", 64'(stat_pause_tx), 64'd0);
    chk("rst tx_held", 64'(tx_held), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    cfg_tx_pause_enable = 1'b1;
    tick(3);

    // Basic XOFF frame with two-cycle request latency.
    xoff_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t1 no beat after 1 cycle", 64'(m_axis.tvalid), 64'd0);
    @(negedge clk);
    chk("t1 beat after 2 cycles", 64'(m_axis.tvalid), 64'd1);
    chk("t1 beat0 const", m_axis.tdata, 64'h1100010000C28001);
    push_pause(48'h001122334455, 16'hFFFF);
    compare_all("t1");
    tick(3);
    chk("t1 stat pulses", 64'(stat_cnt), 64'd1);
    tick(30);
    xoff_req = 1'b0;
    tick(30);
    chk("t1 no refresh/xon", 64'(cap_q.size()), 64'd0);
    chk("t1 stat total", 64'(stat_cnt), 64'd1);

    // Generation disabled: no frame for a rise.
    cfg_tx_pause_enable = 1'b0;
    tick(1);
    xoff_req = 1'b1;
    tick(5);
    xoff_req = 1'b0;
    tick(10);
    chk("t2 disabled no frame", 64'(cap_q.size()), 64'd0);
    cfg_tx_pause_enable = 1'b1;
    tick(2);

    // Refresh every 100 cycles under random backpressure, then XON on fall.
    stat_base = stat_cnt;
    cfg_mac_sa = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    q = 16'($urandom_range(1, 65535));
    cfg_pause_quanta = q;
    cfg_refresh_interval = 16'd100;
    cfg_xon_enable = 1'b1;
    rand_rdy = 1'b1;
    tick(2);
    start_q.delete();
    xoff_req = 1'b1;
    repeat (350) @(posedge clk);
    #1;
    xoff_req = 1'b0;
    for (int k = 0; k < 4; k++) push_pause(cfg_mac_sa, q);
    push_pause(cfg_mac_sa, 16'h0000);
    compare_all("t3");
    chk("t3 frame starts", 64'(start_q.size()), 64'd5);
    if (start_q.size() == 5)
      for (int k = 0; k < 4; k++)
        chk($sformatf("t3 gap%0d", k), 64'(start_q[k + 1] - start_q[k]), 64'(exp_gap[k]));
    tick(3);
    chk("t3 stat pulses", 64'(stat_cnt - stat_base), 64'd5);
    rand_rdy = 1'b0;
    cfg_refresh_interval = '0;
    tick(3);

    // Partner pause mid-frame: frame completes, next frame held.
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    wait_hs("t4 A0");
    rx_pause_active = 1'b1;
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    wait_hs("t4 A1");
    drive_beat({$urandom, $urandom}, 8'h3F, 1'b1);
    wait_hs("t4 A2");
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    @(negedge clk);
    chk("t4 tx_held", 64'(tx_held), 64'd1);
    chk("t4 held s_tready", 64'(s_axis.tready), 64'd0);
    chk("t4 held m_tvalid", 64'(m_axis.tvalid), 64'd0);
    tick(5);
    @(negedge clk);
    chk("t4 still held", 64'(tx_held), 64'd1);
    @(posedge clk);
    #1;
    rx_pause_active = 1'b0;
    wait_hs("t4 B0");
    drive_beat({$urandom, $urandom}, 8'h01, 1'b1);
    wait_hs("t4 B1");
    compare_all("t4");
    @(negedge clk);
    chk("t4 tx_held clear", 64'(tx_held), 64'd0);

    // XOFF rising during a user frame goes ahead of the queued user frame.
    cfg_xon_enable = 1'b0;
    q = 16'($urandom);
    cfg_pause_quanta = q;
    tick(1);
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    wait_hs("t5 C0");
    xoff_req = 1'b1;
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    wait_hs("t5 C1");
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b1);
    wait_hs("t5 C2");
    push_pause(cfg_mac_sa, q);
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    wait_hs("t5 D0");
    drive_beat({$urandom, $urandom}, 8'h0F, 1'b1);
    wait_hs("t5 D1");
    compare_all("t5");
    xoff_req = 1'b0;
    tick(15);
    chk("t5 no xon when disabled", 64'(cap_q.size()), 64'd0);

    // Rise then fall before the frame starts: one frame, quanta 0.
    cfg_xon_enable = 1'b1;
    cfg_pause_quanta = 16'($urandom_range(1, 65535));
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    wait_hs("t6 E0");
    xoff_req = 1'b1;
    tick(1);
    xoff_req = 1'b0;
    tick(3);
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b1);
    wait_hs("t6 E1");
    push_pause(cfg_mac_sa, 16'h0000);
    compare_all("t6");
    tick(20);
    chk("t6 single frame", 64'(cap_q.size()), 64'd0);

    // XON request on the same cycle as the final XOFF beat stays pending.
    stat_base = stat_cnt;
    q = 16'($urandom_range(1, 65535));
    cfg_pause_quanta = q;
    xoff_req = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    xoff_req = 1'b0;
    push_pause(cfg_mac_sa, q);
    push_pause(cfg_mac_sa, 16'h0000);
    compare_all("t7");
    tick(3);
    chk("t7 stat pulses", 64'(stat_cnt - stat_base), 64'd2);

    // Reset during beat 4: output drops at once, nothing resumes afterwards.
    q = 16'($urandom);
    cfg_pause_quanta = q;
    xoff_req = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t8 beats before reset", 64'(cap_q.size()), 64'd4);
    stat_base = stat_cnt;
    aresetn = 1'b0;
    xoff_req = 1'b0;
    #1;
    chk("t8 tvalid drops in reset", 64'(m_axis.tvalid), 64'd0);
    push_pause(cfg_mac_sa, q);
    repeat (4) void'(exp_q.pop_back());
    compare_all("t8");
    tick(2);
    aresetn = 1'b1;
    tick(30);
    chk("t8 no frame after reset", 64'(cap_q.size()), 64'd0);
    chk("t8 no stat after reset", 64'(stat_cnt - stat_base), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
